// File: rtl/bldc_pkg.sv
// Shared BLDC controller types: ADC scheduler state encoding
// and ADC command/response field widths.
package bldc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WAIT,
    S_DONE
  } sched_state_e;

  localparam int ADC_CH_W   = 5;
  localparam int ADC_DATA_W = 12;

endpackage

// File: rtl/bldc_adc_sched.sv
// ADC sweep scheduler: one conversion sweep per PWM centre trigger,
// single command outstanding, per-channel result strobes.
module bldc_adc_sched
  import bldc_pkg::*;
#(
  parameter int NCH   = 6,
  parameter int TMO   = 200,
  parameter int TMO_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  trig_i,
  output logic                  cmd_vld_o,
  output logic [ADC_CH_W-1:0]   cmd_ch_o,
  output logic                  cmd_sop_o,
  output logic                  cmd_eop_o,
  input  logic                  cmd_ready_i,
  input  logic                  rsp_vld_i,
  input  logic [ADC_CH_W-1:0]   rsp_ch_i,
  input  logic [ADC_DATA_W-1:0] rsp_data_i,
  output logic                  data_we_o,
  output logic [2:0]            data_idx_o,
  output logic [ADC_DATA_W-1:0] data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  tmo_o,
  output logic                  ovr_o
);

  localparam logic [2:0]       LAST  = 3'(NCH - 1);
  localparam logic [TMO_W-1:0] TMO_C = TMO_W'(TMO);

  sched_state_e     state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [TMO_W-1:0] cnt_q;
  logic             trig_q;
  logic             edge_w;
  logic             accept;
  logic             match;
  logic             tmo_hit;

  assign edge_w  = trig_i & ~trig_q;
  assign accept  = (state_q == S_CMD) & cmd_ready_i;
  assign match   = (state_q == S_WAIT) & rsp_vld_i
                 & (rsp_ch_i == {2'b00, idx_q});
  // a matching response in the final cycle beats the timeout
  assign tmo_hit = (state_q == S_WAIT) & ~match
                 & (cnt_q == TMO_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (edge_w & en_i) begin
          state_d = S_CMD;
          idx_d   = '0;
        end
      end
      S_CMD: begin
        if (cmd_ready_i) begin
          state_d = S_WAIT;
        end else if (!en_i) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      S_WAIT: begin
        if (match) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else if (en_i) begin
            state_d = S_CMD;
            idx_d   = idx_q + 3'd1;
          end else begin
            state_d = S_IDLE;
            idx_d   = '0;
          end
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cmd_vld_o = (state_q == S_CMD);
    cmd_ch_o  = {2'b00, idx_q};
    cmd_sop_o = cmd_vld_o & (idx_q == 3'd0);
    cmd_eop_o = cmd_vld_o & (idx_q == LAST);
    busy_o    = (state_q != S_IDLE);
    done_o    = (state_q == S_DONE);
    tmo_o     = tmo_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q     <= 1'b0;
      cnt_q      <= '0;
      data_we_o  <= 1'b0;
      data_idx_o <= '0;
      data_o     <= '0;
      ovr_o      <= 1'b0;
    end else begin
      trig_q    <= trig_i;
      ovr_o     <= edge_w & (state_q != S_IDLE);
      data_we_o <= match;
      if (match) begin
        data_idx_o <= idx_q;
        data_o     <= rsp_data_i;
      end
      if (accept) begin
        cnt_q <= '0;
      end else if ((state_q == S_WAIT) & ~match & ~tmo_hit) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bldc_adc_sched.sv
// Directed bench for bldc_adc_sched: full sweeps, backpressure,
// timeout, overrun, stray responses, enable drop and reset.
module tb_bldc_adc_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic        trig_i;
  logic        cmd_vld_o;
  logic [4:0]  cmd_ch_o;
  logic        cmd_sop_o;
  logic        cmd_eop_o;
  logic        cmd_ready_i;
  logic        rsp_vld_i;
  logic [4:0]  rsp_ch_i;
  logic [11:0] rsp_data_i;
  logic        data_we_o;
  logic [2:0]  data_idx_o;
  logic [11:0] data_o;
  logic        busy_o;
  logic        done_o;
  logic        tmo_o;
  logic        ovr_o;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int n_tmo = 0;
  int n_ovr = 0;
  int n_we = 0;
  int b_done, b_tmo, b_ovr, b_we;

  always #5 clk = ~clk;

  bldc_adc_sched #(.NCH(6), .TMO(200), .TMO_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en_i),
    .trig_i      (trig_i),
    .cmd_vld_o   (cmd_vld_o),
    .cmd_ch_o    (cmd_ch_o),
    .cmd_sop_o   (cmd_sop_o),
    .cmd_eop_o   (cmd_eop_o),
    .cmd_ready_i (cmd_ready_i),
    .rsp_vld_i   (rsp_vld_i),
    .rsp_ch_i    (rsp_ch_i),
    .rsp_data_i  (rsp_data_i),
    .data_we_o   (data_we_o),
    .data_idx_o  (data_idx_o),
    .data_o      (data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .tmo_o       (tmo_o),
    .ovr_o       (ovr_o)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (done_o)    n_done++;
      if (tmo_o)     n_tmo++;
      if (ovr_o)     n_ovr++;
      if (data_we_o) n_we++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic snap;
    b_done = n_done;
    b_tmo  = n_tmo;
    b_ovr  = n_ovr;
    b_we   = n_we;
  endtask

  task automatic start_sweep;
    trig_i = 1'b1;
    tick;
    trig_i = 1'b0;
    chk("start_vld", 32'(cmd_vld_o), 32'd1);
    chk("start_sop", 32'(cmd_sop_o), 32'd1);
  endtask

  // mode 0 normal, 1 trigger edge in WAIT, 2 stray channel-4 response
  task automatic do_ch(input int ch, input int hold, input int mode);
    chk("cmd_vld", 32'(cmd_vld_o), 32'd1);
    chk("cmd_ch", 32'(cmd_ch_o), 32'(ch));
    chk("cmd_sop", 32'(cmd_sop_o), 32'(ch == 0));
    chk("cmd_eop", 32'(cmd_eop_o), 32'(ch == 5));
    for (int i = 0; i < hold; i++) begin
      cmd_ready_i = 1'b0;
      tick;
      chk("hold_vld", 32'(cmd_vld_o), 32'd1);
      chk("hold_ch", 32'(cmd_ch_o), 32'(ch));
    end
    cmd_ready_i = 1'b1;
    tick;
    chk("wait_busy", 32'(busy_o), 32'd1);
    chk("wait_vld", 32'(cmd_vld_o), 32'd0);
    if (mode == 1) trig_i = 1'b1;
    tick;
    if (mode == 1) begin
      chk("ovr_pulse", 32'(ovr_o), 32'd1);
      trig_i = 1'b0;
    end
    if (mode == 2) begin
      rsp_vld_i  = 1'b1;
      rsp_ch_i   = 5'd4;
      rsp_data_i = 12'hABC;
    end
    tick;
    chk("no_we", 32'(data_we_o), 32'd0);
    rsp_vld_i  = 1'b1;
    rsp_ch_i   = 5'(ch);
    rsp_data_i = 12'(12'h100 + ch);
    tick;
    rsp_vld_i = 1'b0;
    chk("we", 32'(data_we_o), 32'd1);
    chk("we_idx", 32'(data_idx_o), 32'(ch));
    chk("we_data", 32'(data_o), 32'(12'h100 + ch));
    if (ch == 5) begin
      chk("done", 32'(done_o), 32'd1);
      tick;
      chk("end_busy", 32'(busy_o), 32'd0);
      chk("done_clr", 32'(done_o), 32'd0);
    end else begin
      chk("next_vld", 32'(cmd_vld_o), 32'd1);
    end
  endtask

  initial begin
    rst         = 1'b1;
    en_i        = 1'b1;
    trig_i      = 1'b0;
    cmd_ready_i = 1'b1;
    rsp_vld_i   = 1'b0;
    rsp_ch_i    = 5'd0;
    rsp_data_i  = 12'h000;
    repeat (3) tick;
    chk("rst_vld", 32'(cmd_vld_o), 32'd0);
    chk("rst_ch", 32'(cmd_ch_o), 32'd0);
    chk("rst_sop", 32'(cmd_sop_o), 32'd0);
    chk("rst_eop", 32'(cmd_eop_o), 32'd0);
    chk("rst_we", 32'(data_we_o), 32'd0);
    chk("rst_idx", 32'(data_idx_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_tmo", 32'(tmo_o), 32'd0);
    chk("rst_ovr", 32'(ovr_o), 32'd0);
    rst = 1'b0;
    tick;

    // plain sweep
    snap;
    start_sweep;
    for (int c = 0; c < 6; c++) do_ch(c, 0, 0);
    chk("s1_done", 32'(n_done - b_done), 32'd1);
    chk("s1_tmo", 32'(n_tmo - b_tmo), 32'd0);
    chk("s1_ovr", 32'(n_ovr - b_ovr), 32'd0);
    chk("s1_we", 32'(n_we - b_we), 32'd6);

    // backpressure on ch2
    snap;
    start_sweep;
    for (int c = 0; c < 6; c++) do_ch(c, (c == 2) ? 10 : 0, 0);
    chk("s2_done", 32'(n_done - b_done), 32'd1);
    chk("s2_we", 32'(n_we - b_we), 32'd6);

    // timeout on ch3
    snap;
    start_sweep;
    for (int c = 0; c < 3; c++) do_ch(c, 0, 0);
    chk("t_ch", 32'(cmd_ch_o), 32'd3);
    tick;
    repeat (199) tick;
    chk("t_early", 32'(tmo_o), 32'd0);
    tick;
    chk("t_pulse", 32'(tmo_o), 32'd1);
    tick;
    chk("t_tmo_clr", 32'(tmo_o), 32'd0);
    chk("t_busy", 32'(busy_o), 32'd0);
    chk("t_vld", 32'(cmd_vld_o), 32'd0);
    chk("t_done", 32'(n_done - b_done), 32'd0);
    chk("t_cnt", 32'(n_tmo - b_tmo), 32'd1);
    start_sweep;
    for (int c = 0; c < 6; c++) do_ch(c, 0, 0);
    chk("t_restart", 32'(n_done - b_done), 32'd1);

    // response arriving exactly at the timeout limit
    snap;
    start_sweep;
    tick;
    repeat (200) tick;
    rsp_vld_i  = 1'b1;
    rsp_ch_i   = 5'd0;
    rsp_data_i = 12'h100;
    #1;
    chk("edge_tmo", 32'(tmo_o), 32'd0);
    tick;
    rsp_vld_i = 1'b0;
    chk("edge_we", 32'(data_we_o), 32'd1);
    for (int c = 1; c < 6; c++) do_ch(c, 0, 0);
    chk("edge_ntmo", 32'(n_tmo - b_tmo), 32'd0);
    chk("edge_done", 32'(n_done - b_done), 32'd1);

    // overrun during ch1 WAIT
    snap;
    start_sweep;
    for (int c = 0; c < 6; c++) do_ch(c, 0, (c == 1) ? 1 : 0);
    chk("o_ovr", 32'(n_ovr - b_ovr), 32'd1);
    chk("o_done", 32'(n_done - b_done), 32'd1);

    // stray channel-4 response while waiting ch1
    snap;
    start_sweep;
    for (int c = 0; c < 6; c++) do_ch(c, 0, (c == 1) ? 2 : 0);
    chk("w_we", 32'(n_we - b_we), 32'd6);
    chk("w_done", 32'(n_done - b_done), 32'd1);

    // edge in IDLE with enable low
    snap;
    en_i   = 1'b0;
    trig_i = 1'b1;
    tick;
    trig_i = 1'b0;
    chk("i_busy", 32'(busy_o), 32'd0);
    tick;
    chk("i_ovr", 32'(n_ovr - b_ovr), 32'd0);
    chk("i_busy2", 32'(busy_o), 32'd0);
    en_i = 1'b1;

    // enable dropped in CMD on ch2
    snap;
    start_sweep;
    do_ch(0, 0, 0);
    do_ch(1, 0, 0);
    cmd_ready_i = 1'b0;
    en_i        = 1'b0;
    tick;
    chk("e_vld", 32'(cmd_vld_o), 32'd0);
    chk("e_busy", 32'(busy_o), 32'd0);
    en_i        = 1'b1;
    cmd_ready_i = 1'b1;
    tick;
    chk("e_done", 32'(n_done - b_done), 32'd0);

    // reset while waiting, with a matching response pending
    start_sweep;
    tick;
    chk("r_wait", 32'(busy_o), 32'd1);
    rsp_vld_i  = 1'b1;
    rsp_ch_i   = 5'd0;
    rsp_data_i = 12'h555;
    rst        = 1'b1;
    tick;
    rsp_vld_i = 1'b0;
    chk("r_we", 32'(data_we_o), 32'd0);
    chk("r_data", 32'(data_o), 32'd0);
    chk("r_idx", 32'(data_idx_o), 32'd0);
    chk("r_busy", 32'(busy_o), 32'd0);
    chk("r_vld", 32'(cmd_vld_o), 32'd0);
    chk("r_ovr", 32'(ovr_o), 32'd0);
    rst = 1'b0;
    tick;
    chk("r_idle", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
